// File: rtl/v2k_pkg.sv
// Shared types, defaults and helpers for the v2k change-capture slice.
package v2k_pkg;

  localparam int unsigned V2K_WIDTH_DFLT    = 16;
  localparam int unsigned V2K_TS_WIDTH_DFLT = 16;
  localparam int unsigned V2K_DEPTH_DFLT    = 8;

  typedef struct packed {
    logic [V2K_WIDTH_DFLT:0]      data;
    logic [V2K_TS_WIDTH_DFLT-1:0] ts;
  } v2k_entry_t;

  function automatic int unsigned v2k_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/v2k_sync_fifo.sv
// Single-clock FIFO with a registered head word, registered occupancy and full/empty flags.
module v2k_sync_fifo
  import v2k_pkg::*;
#(
  parameter int unsigned EW    = 33,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = v2k_clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [EW-1:0] din,
  output logic [EW-1:0] head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d, remaining;
  logic [EW-1:0] head_q, head_d;
  logic          full_q, empty_q;
  logic          push_ok, pop_ok;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign pop_ok  = pop && !empty_q;
  assign push_ok = push && (!full_q || pop_ok);

  always_comb begin
    wptr_d    = wptr_q + (AW + 1)'(push_ok);
    rptr_d    = rptr_q + (AW + 1)'(pop_ok);
    count_d   = count_q + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
    remaining = count_q - (AW + 1)'(pop_ok);
    head_d    = head_q;
    // When nothing older survives the pop, the incoming word becomes the new head directly.
    if (push_ok && (remaining == '0)) begin
      head_d = din;
    end else if (remaining != '0) begin
      head_d = mem_q[rptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      head_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      head_q  <= head_d;
      full_q  <= (count_d == (AW + 1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= din;
  end

  assign head  = head_q;
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/v2k_change_fifo.sv
// Timestamps every change of the sampled word and queues {value, timestamp} entries for a
// valid/ready consumer, with a sticky flag for entries lost to a full queue.
module v2k_change_fifo
  import v2k_pkg::*;
#(
  parameter int unsigned WIDTH    = V2K_WIDTH_DFLT,
  parameter int unsigned DEPTH    = V2K_DEPTH_DFLT,
  parameter int unsigned TS_WIDTH = V2K_TS_WIDTH_DFLT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH:0]           sig,
  input  logic                     ovf_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH:0]           out_data,
  output logic [TS_WIDTH-1:0]      out_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  typedef struct packed {
    logic [WIDTH:0]      data;
    logic [TS_WIDTH-1:0] ts;
  } entry_t;

  logic [TS_WIDTH-1:0] ts_q;
  logic [WIDTH:0]      prev_q;
  logic                prev_vld_q, ovf_q;
  logic                evt, pop, drop, full, empty;
  entry_t              din, head;

  assign evt  = !prev_vld_q || (sig != prev_q);
  assign pop  = !empty && out_ready;
  assign drop = evt && full && !pop;
  assign din  = '{data: sig, ts: ts_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q       <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      ts_q       <= ts_q + TS_WIDTH'(1);
      prev_q     <= sig;
      prev_vld_q <= 1'b1;
      // A drop in the same cycle as a clear request keeps the flag set.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  v2k_sync_fifo #(
    .EW    ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (evt),
    .pop   (out_ready),
    .din   (din),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out_data  = head.data;
  assign out_ts    = head.ts;
  assign overflow  = ovf_q;

endmodule
